// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus responder: register map, oversampling
// ratio and the transmitter/receiver state encodings.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  localparam int OVERSAMPLE = 16;

  // Last tick index of a bit period, and the tick index at the bit centre.
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: holds the 16-bit divisor and emits a one-cycle tick
// every (divisor+1) clocks. A divisor byte write restarts the period with the
// newly assembled value one cycle later.
module spart_baud_gen #(
  parameter logic [15:0] DB_RESET = 16'd325
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  wr_data,
  output logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] div_reg;
  logic [15:0] cnt_reg;
  logic        reload_reg;

  // Divisor register, byte-writable; reload request follows any byte write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg    <= DB_RESET;
      reload_reg <= 1'b0;
    end else begin
      if (wr_lo) div_reg[7:0]  <= wr_data;
      if (wr_hi) div_reg[15:8] <= wr_data;
      reload_reg <= wr_lo | wr_hi;
    end
  end

  // Down-counter: reload on expiry or after a divisor update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= DB_RESET;
    end else if (reload_reg || (cnt_reg == 16'd0)) begin
      cnt_reg <= div_reg;
    end else begin
      cnt_reg <= cnt_reg - 16'd1;
    end
  end

  assign tick    = (cnt_reg == 16'd0);
  assign divisor = div_reg;

endmodule

// File: rtl/spart_bus_resp.sv
// SPART peripheral: processor bus decode and databus driver, 8N1 transmitter
// and receiver sharing one 16x oversampling baud tick, status on rda/tbr.
module spart_bus_resp
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  // ---------------- bus decode ----------------
  logic        rd_en, wr_en;
  logic        wr_tx, wr_dbl, wr_dbh, rd_rx;
  logic [7:0]  rd_mux;
  logic [15:0] divisor;
  logic        tick;

  assign rd_en  = iocs & iorw;
  assign wr_en  = iocs & ~iorw;
  assign wr_tx  = wr_en & (ioaddr == ADDR_DATA);
  assign wr_dbl = wr_en & (ioaddr == ADDR_DBL);
  assign wr_dbh = wr_en & (ioaddr == ADDR_DBH);
  assign rd_rx  = rd_en & (ioaddr == ADDR_DATA);

  logic [7:0] rx_data_reg, rx_data_next;
  logic       rda_reg, rda_next;

  // Read data selection; the bus is only driven during a selected read.
  always_comb begin
    rd_mux = 8'h00;
    case (ioaddr)
      ADDR_DATA:   rd_mux = rx_data_reg;
      ADDR_STATUS: rd_mux = {6'b0, tbr, rda};
      ADDR_DBL:    rd_mux = divisor[7:0];
      ADDR_DBH:    rd_mux = divisor[15:8];
      default:     rd_mux = 8'h00;
    endcase
  end

  assign databus = rd_en ? rd_mux : 8'bz;

  spart_baud_gen #(.DB_RESET(DB_RESET)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .wr_lo   (wr_dbl),
    .wr_hi   (wr_dbh),
    .wr_data (databus),
    .divisor (divisor),
    .tick    (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t  tx_state_reg, tx_state_next;
  logic [3:0] tx_tick_reg, tx_tick_next;
  logic [2:0] tx_bit_reg, tx_bit_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic       txd_reg, txd_next;

  // TX state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_reg <= TX_IDLE;
      tx_tick_reg  <= 4'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'h00;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_tick_reg  <= tx_tick_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
    end
  end

  // TX next state. In START, txd still high means the first tick has not
  // arrived yet; that tick drops the line and begins the start-bit count.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_tick_next  = tx_tick_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = txd_reg;
    case (tx_state_reg)
      TX_IDLE: begin
        if (wr_tx) begin
          tx_shift_next = databus;
          tx_tick_next  = 4'd0;
          tx_bit_next   = 3'd0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          if (txd_reg) begin
            txd_next     = 1'b0;
            tx_tick_next = 4'd0;
          end else if (tx_tick_reg == TICK_LAST) begin
            tx_tick_next  = 4'd0;
            tx_bit_next   = 3'd0;
            txd_next      = tx_shift_reg[0];
            tx_state_next = TX_DATA;
          end else begin
            tx_tick_next = tx_tick_reg + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_tick_reg == TICK_LAST) begin
            tx_tick_next = 4'd0;
            if (tx_bit_reg == 3'd7) begin
              txd_next      = 1'b1;
              tx_state_next = TX_STOP;
            end else begin
              tx_shift_next = {1'b0, tx_shift_reg[7:1]};
              txd_next      = tx_shift_reg[1];
              tx_bit_next   = tx_bit_reg + 3'd1;
            end
          end else begin
            tx_tick_next = tx_tick_reg + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_tick_reg == TICK_LAST) begin
            tx_tick_next  = 4'd0;
            tx_state_next = TX_IDLE;
          end else begin
            tx_tick_next = tx_tick_reg + 4'd1;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  assign tbr = (tx_state_reg == TX_IDLE);
  assign txd = txd_reg;

  // ---------------- receiver ----------------
  logic       rx_meta_reg, rx_sync_reg, rx_prev_reg;
  rx_state_t  rx_state_reg, rx_state_next;
  logic [3:0] rx_tick_reg, rx_tick_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic       frame_done;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rxd;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // RX state register, received byte and data-available flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_reg <= RX_IDLE;
      rx_tick_reg  <= 4'd0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'h00;
      rx_data_reg  <= 8'h00;
      rda_reg      <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_tick_reg  <= rx_tick_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rda_reg      <= rda_next;
    end
  end

  // RX next state: validate the start bit at its centre, then sample every
  // 16 ticks. A completing frame takes priority over a data-register read.
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_tick_next  = rx_tick_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    frame_done    = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_tick_next  = 4'd0;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tick_reg == TICK_MID) begin
            rx_tick_next  = 4'd0;
            rx_bit_next   = 3'd0;
            rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_next = rx_tick_reg + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_tick_reg == TICK_LAST) begin
            rx_tick_next  = 4'd0;
            rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) begin
              rx_state_next = RX_STOP;
            end else begin
              rx_bit_next = rx_bit_reg + 3'd1;
            end
          end else begin
            rx_tick_next = rx_tick_reg + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_tick_reg == TICK_LAST) begin
            rx_tick_next  = 4'd0;
            rx_state_next = RX_IDLE;
            frame_done    = rx_sync_reg;
          end else begin
            rx_tick_next = rx_tick_reg + 4'd1;
          end
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase

    rx_data_next = rx_data_reg;
    rda_next     = rda_reg;
    if (rd_rx) rda_next = 1'b0;
    if (frame_done) begin
      rda_next     = 1'b1;
      rx_data_next = rx_shift_reg;
    end
  end

  assign rda = rda_reg;

endmodule

// File: doc/spart_bus_resp.md
Name: spart_bus_resp

Overview:
- Peripheral end of the SPART processor bus: decodes iocs/iorw/ioaddr, owns the databus tristate, and holds the baud divisor, transmit and receive registers.
- Contains a 16x-oversampling baud tick generator, an 8N1 transmitter and an 8N1 receiver; reports status on rda/tbr.
- Sits between the processor-side driver and the serial pins txd/rxd.

Parameters:
- DB_RESET, 16'd325, divisor loaded at reset; tick period = (divisor+1) clk cycles, 16 ticks per bit.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-low reset
- iocs  input  1  chip select; bus access valid only when 1
- iorw  input  1  1 = read (responder drives databus), 0 = write
- ioaddr  input  2  00 data (TX write / RX read), 01 status, 10 divisor low byte, 11 divisor high byte
- databus  inout  8  bidirectional data bus
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready (transmitter idle, accepts a byte)
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous to clk

Behaviour:
- Reset (rst=0, async): txd=1, tbr=1, rda=0, databus Z, divisor=DB_RESET, rx_data=0, baud counter=DB_RESET, TX/RX FSMs IDLE.
- Databus driven combinationally only when iocs=1 and iorw=1; otherwise Z. Read mux: 00 rx_data, 01 {6'b0,tbr,rda}, 10 divisor[7:0], 11 divisor[15:8].
- Writes are sampled at posedge when iocs=1, iorw=0:
  - 10/11 update one divisor byte.
  - 01 is ignored.
  - 00 loads TX only if tbr=1; a write while tbr=0 is dropped.
- Baud gen: 16-bit down-counter. tick=1 for one cycle when count==0, then reloads divisor. Any divisor write reloads the counter with the new assembled value on the next cycle. Divisor 0 gives a tick every cycle.
- TX FSM, states IDLE, START, DATA, STOP:
  - Write at edge N: tbr=0 from N+1, FSM moves to START.
  - txd=0 from the first tick after load, for 16 ticks.
  - 8 data bits LSB first, 16 ticks each.
  - Stop bit txd=1 for 16 ticks.
  - tbr=1 in the cycle after the 16th stop tick; returns to IDLE.
- RX front end: rxd passes through a 2-flop synchronizer; the FSM uses the synchronized value only.
- RX FSM, states IDLE, START, DATA, STOP:
  - In IDLE, a synced falling edge starts the tick count.
  - At tick 8 rxd must still be 0, else return to IDLE (glitch reject).
  - Data bits are sampled every 16 ticks thereafter (bit centres), LSB first.
  - Stop sample=1: rx_data is updated and rda set in the same cycle.
  - Stop sample=0 (framing error): frame discarded, rx_data and rda unchanged, return to IDLE.
- rda is cleared by a read of addr 00 (iocs=1, iorw=1, ioaddr=00) at posedge. If a frame completes in the same cycle as that read, the new frame wins: rda stays 1 and rx_data takes the new byte.
- Overrun: a new frame overwrites rx_data while rda=1; no error flag.
- TX and RX are fully independent, so simultaneous operation is legal.
- A divisor change mid-frame takes effect on the next tick period; the frame is not aborted.
- Reset asserted mid-frame: immediate return to reset values, txd=1.

Decomposition:
- Shared package spart_pkg:
  - address constants ADDR_DATA=2'b00, ADDR_STATUS=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11
  - OVERSAMPLE=16
  - TX/RX state enums
- One sub-module, spart_baud_gen: divisor register, down-counter, tick output, byte-write inputs. TX/RX FSMs and the bus decode stay in spart_bus_resp.

Test Plan:
- Reset with DB_RESET=1 -> txd=1, tbr=1, rda=0, databus Z; read addr 10/11 returns 8'h01/8'h00.
- Write 8'hA5 to addr 00 with divisor 1 -> tbr=0 next cycle; txd frame 0,1,0,1,0,0,1,0,1,1, each bit 32 clk; tbr=1 one cycle after stop ends (about 320 clk).
- Loop txd to rxd, send 8'h3C -> rda=1 at stop-bit centre, status read 8'h03 after tbr returns; read addr 00 gives 8'h3C and rda=0 next cycle.
- 2-tick-wide low pulse on rxd -> no frame received, rda stays 0; frame with stop bit 0 -> rda stays 0, rx_data unchanged.
- Write addr 00 while tbr=0 -> byte dropped, current frame bits unchanged; write 10/11 = 8'h00/8'h00 mid-frame -> subsequent bits 16 clk each.
- Assert rst mid-TX frame -> txd=1, tbr=1 immediately (asynchronous); with rda=1, read addr 00 coincident with a new frame completing -> rda stays 1, new byte returned on the next read.
